// File: rtl/balu_arb.sv
// Two-port arbiter in front of a shared bit-manipulation unit: grants one request,
// issues it to the unit, then holds the result for the granted port until consumed.
module balu_arb #(
   parameter int RR_EN = 1,
   parameter int FNW   = 6
) (
   input  logic           ise_clk,
   input  logic           ise_rst,

   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [FNW-1:0] req0_fn,
   input  logic [63:0]    req0_in1,
   input  logic [63:0]    req0_in2,
   output logic           rsp0_valid,
   input  logic           rsp0_ready,
   output logic [63:0]    rsp0_data,

   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [FNW-1:0] req1_fn,
   input  logic [63:0]    req1_in1,
   input  logic [63:0]    req1_in2,
   output logic           rsp1_valid,
   input  logic           rsp1_ready,
   output logic [63:0]    rsp1_data,

   output logic           alu_val,
   output logic [FNW-1:0] alu_fn,
   output logic [63:0]    alu_in1,
   output logic [63:0]    alu_in2,
   input  logic           alu_oval,
   input  logic [63:0]    alu_out
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t         state;
   logic           lp;
   logic           g;
   logic           gsel;
   logic           take;
   logic           rsp_ack;
   logic [FNW-1:0] fn_q;
   logic [63:0]    in1_q;
   logic [63:0]    in2_q;
   logic [63:0]    res_q;

   // Grant selection; ready is gated by reset so it reads 0 while the block is held.
   always_comb begin
      take = (state == IDLE) && !ise_rst && (req0_valid || req1_valid);
      if (req0_valid && req1_valid)
         gsel = (RR_EN != 0) ? ~lp : 1'b0;
      else
         gsel = req1_valid;
      req0_ready = take && !gsel;
      req1_ready = take && gsel;
      rsp_ack    = g ? rsp1_ready : rsp0_ready;
   end

   always_ff @(posedge ise_clk or posedge ise_rst) begin
      if (ise_rst) begin
         state      <= IDLE;
         lp         <= 1'b1;
         g          <= 1'b0;
         fn_q       <= '0;
         in1_q      <= '0;
         in2_q      <= '0;
         res_q      <= '0;
         alu_val    <= 1'b0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  g       <= gsel;
                  lp      <= gsel;
                  fn_q    <= gsel ? req1_fn  : req0_fn;
                  in1_q   <= gsel ? req1_in1 : req0_in1;
                  in2_q   <= gsel ? req1_in2 : req0_in2;
                  alu_val <= 1'b1;
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               if (alu_oval) begin
                  res_q      <= alu_out;
                  alu_val    <= 1'b0;
                  rsp0_valid <= !g;
                  rsp1_valid <= g;
                  state      <= RESP;
               end
            end
            RESP: begin
               if (rsp_ack) begin
                  rsp0_valid <= 1'b0;
                  rsp1_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               state      <= IDLE;
               alu_val    <= 1'b0;
               rsp0_valid <= 1'b0;
               rsp1_valid <= 1'b0;
            end
         endcase
      end
   end

   assign alu_fn    = fn_q;
   assign alu_in1   = in1_q;
   assign alu_in2   = in2_q;
   assign rsp0_data = res_q;
   assign rsp1_data = res_q;

endmodule

// File: tb/tb_balu_arb.sv
// Bench for balu_arb: directed scenarios plus randomized traffic against a transaction-level model.
module tb_balu_arb;
   localparam int FNW = 6;

   logic           ise_clk = 1'b0;
   logic           ise_rst = 1'b1;
   logic           req0_valid, req1_valid, rsp0_ready, rsp1_ready, alu_oval;
   logic [FNW-1:0] req0_fn, req1_fn;
   logic [63:0]    req0_in1, req0_in2, req1_in1, req1_in2;

   logic           req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_val;
   logic [63:0]    rsp0_data, rsp1_data, alu_in1, alu_in2, alu_out;
   logic [FNW-1:0] alu_fn;

   logic           fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid, fp_alu_val;
   logic [63:0]    fp_rsp0_data, fp_rsp1_data, fp_alu_in1, fp_alu_in2, fp_alu_out;
   logic [FNW-1:0] fp_alu_fn;

   int vec  = 0;
   int errs = 0;

   always #5 ise_clk = ~ise_clk;

   // Unit model: ANDN, XOR, OR; anything else returns 0. Garbage while not valid.
   function automatic logic [63:0] alu_ref(input logic [FNW-1:0] fn, input logic [63:0] a, input logic [63:0] b);
      case (fn)
         6'd35:   return a & ~b;
         6'd1:    return a ^ b;
         6'd2:    return a | b;
         default: return 64'd0;
      endcase
   endfunction

   assign alu_out    = alu_oval ? alu_ref(alu_fn, alu_in1, alu_in2) : 64'hDEAD_BEEF_0BAD_F00D;
   assign fp_alu_out = alu_oval ? alu_ref(fp_alu_fn, fp_alu_in1, fp_alu_in2) : 64'hDEAD_BEEF_0BAD_F00D;

   balu_arb #(.RR_EN(1), .FNW(FNW)) dut (
      .ise_clk(ise_clk), .ise_rst(ise_rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fn(req0_fn), .req0_in1(req0_in1), .req0_in2(req0_in2),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fn(req1_fn), .req1_in1(req1_in1), .req1_in2(req1_in2),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
      .alu_val(alu_val), .alu_fn(alu_fn), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_oval(alu_oval), .alu_out(alu_out)
   );

   balu_arb #(.RR_EN(0), .FNW(FNW)) dut_fp (
      .ise_clk(ise_clk), .ise_rst(ise_rst),
      .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_fn(req0_fn), .req0_in1(req0_in1), .req0_in2(req0_in2),
      .rsp0_valid(fp_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(fp_rsp0_data),
      .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_fn(req1_fn), .req1_in1(req1_in1), .req1_in2(req1_in2),
      .rsp1_valid(fp_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(fp_rsp1_data),
      .alu_val(fp_alu_val), .alu_fn(fp_alu_fn), .alu_in1(fp_alu_in1), .alu_in2(fp_alu_in2),
      .alu_oval(alu_oval), .alu_out(fp_alu_out)
   );

   task automatic cyc;
      @(posedge ise_clk);
      #1;
   endtask

   task automatic clear_inputs;
      req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0; alu_oval = 1;
      req0_fn = '0; req1_fn = '0; req0_in1 = '0; req0_in2 = '0; req1_in1 = '0; req1_in2 = '0;
   endtask

   task automatic do_reset;
      ise_rst = 1;
      clear_inputs();
      cyc(); cyc();
      ise_rst = 0;
   endtask

   task automatic test_reset;
      ise_rst = 1;
      clear_inputs();
      req0_valid = 1; req1_valid = 1; req0_in1 = 64'h1234; req1_in1 = 64'h5678; req0_fn = 6'd35;
      #1;
      vec++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_val} !== 5'b0) begin
         errs++; $display("FAIL reset_ctl: got %b expected 00000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_val});
      end
      vec++;
      if ({alu_fn, alu_in1, alu_in2} !== '0) begin
         errs++; $display("FAIL reset_alu_bus: got fn=%h in1=%h in2=%h expected all 0", alu_fn, alu_in1, alu_in2);
      end
      vec++;
      if ({rsp0_data, rsp1_data} !== '0) begin
         errs++; $display("FAIL reset_rsp_data: got %h/%h expected 0", rsp0_data, rsp1_data);
      end
      cyc();
      req0_valid = 0; req1_valid = 0;
      ise_rst = 0;
      cyc();
      req1_valid = 1;
      #1;
      vec++;
      if ({req1_ready, req0_ready} !== 2'b10) begin
         errs++; $display("FAIL first_cycle_grant: got %b expected 10", {req1_ready, req0_ready});
      end
      req1_valid = 0;
   endtask

   task automatic test_single_op;
      do_reset();
      cyc();
      req0_valid = 1; req0_fn = 6'd35; req0_in1 = 64'hFF00; req0_in2 = 64'h0F00; rsp0_ready = 1;
      #1;
      vec++;
      if ({req1_ready, req0_ready} !== 2'b01 || alu_val !== 1'b0) begin
         errs++; $display("FAIL single_accept: got rdy=%b alu_val=%b expected 01/0", {req1_ready, req0_ready}, alu_val);
      end
      cyc();
      req0_valid = 0;
      #1;
      vec++;
      if (alu_val !== 1'b1 || alu_fn !== 6'd35 || alu_in1 !== 64'hFF00 || alu_in2 !== 64'h0F00 || rsp0_valid !== 1'b0) begin
         errs++; $display("FAIL single_issue: got val=%b fn=%0d in1=%h in2=%h rspv=%b expected 1/35/ff00/0f00/0",
                          alu_val, alu_fn, alu_in1, alu_in2, rsp0_valid);
      end
      cyc();
      vec++;
      if (rsp0_valid !== 1'b1 || rsp0_data !== 64'hF000 || rsp1_valid !== 1'b0 || alu_val !== 1'b0) begin
         errs++; $display("FAIL single_resp: got v=%b data=%h v1=%b alu_val=%b expected 1/f000/0/0",
                          rsp0_valid, rsp0_data, rsp1_valid, alu_val);
      end
      vec++;
      if (alu_fn !== 6'd35 || alu_in1 !== 64'hFF00 || rsp1_data !== 64'hF000) begin
         errs++; $display("FAIL hold_outside_issue: got fn=%0d in1=%h rsp1_data=%h expected 35/ff00/f000", alu_fn, alu_in1, rsp1_data);
      end
      cyc();
      vec++;
      if (rsp0_valid !== 1'b0) begin
         errs++; $display("FAIL single_release: got rsp0_valid=%b expected 0", rsp0_valid);
      end
   endtask

   task automatic test_tie_rr;
      logic [63:0] exp_res [2];
      do_reset();
      cyc();
      req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
      req0_fn = 6'd1; req0_in1 = {$urandom, $urandom}; req0_in2 = {$urandom, $urandom};
      req1_fn = 6'd2; req1_in1 = {$urandom, $urandom}; req1_in2 = {$urandom, $urandom};
      exp_res[0] = req0_in1 ^ req0_in2;
      exp_res[1] = req1_in1 | req1_in2;
      for (int i = 0; i < 12; i++) begin
         automatic int p = (i / 3) % 2;
         automatic logic [1:0] exp_rdy = (i % 3 == 0) ? (p == 0 ? 2'b01 : 2'b10) : 2'b00;
         if (i > 0) cyc();
         #1;
         vec++;
         if ({req1_ready, req0_ready} !== exp_rdy) begin
            errs++; $display("FAIL tie_grant[%0d]: got %b expected %b", i, {req1_ready, req0_ready}, exp_rdy);
         end
         if (i % 3 == 2) begin
            vec++;
            if ({rsp1_valid, rsp0_valid} !== (p == 0 ? 2'b01 : 2'b10) || rsp0_data !== exp_res[p]) begin
               errs++; $display("FAIL tie_resp[%0d]: got v=%b data=%h expected port %0d data=%h",
                                i, {rsp1_valid, rsp0_valid}, rsp0_data, p, exp_res[p]);
            end
         end
      end
      clear_inputs();
   endtask

   task automatic test_backpressure;
      logic [63:0] exp;
      do_reset();
      cyc();
      req0_valid = 1; req0_fn = 6'd35; req0_in1 = {$urandom, $urandom}; req0_in2 = {$urandom, $urandom};
      exp = req0_in1 & ~req0_in2;
      #1;
      vec++;
      if ({req1_ready, req0_ready} !== 2'b01) begin
         errs++; $display("FAIL bp_accept: got %b expected 01", {req1_ready, req0_ready});
      end
      cyc();
      req0_valid = 0; req1_valid = 1; req1_fn = 6'd1; req1_in1 = 64'h77; req1_in2 = 64'h70;
      for (int i = 0; i < 6; i++) begin
         cyc();
         if (i == 5) rsp0_ready = 1;
         #1;
         vec++;
         if (rsp0_valid !== 1'b1 || rsp0_data !== exp || rsp1_valid !== 1'b0 || req1_ready !== 1'b0) begin
            errs++; $display("FAIL bp_hold[%0d]: got v=%b data=%h v1=%b rdy1=%b expected 1/%h/0/0",
                             i, rsp0_valid, rsp0_data, rsp1_valid, req1_ready, exp);
         end
      end
      cyc();
      rsp0_ready = 0;
      #1;
      vec++;
      if ({req1_ready, req0_ready} !== 2'b10 || rsp0_valid !== 1'b0) begin
         errs++; $display("FAIL bp_next_grant: got rdy=%b rsp0_valid=%b expected 10/0", {req1_ready, req0_ready}, rsp0_valid);
      end
      req1_valid = 0; rsp1_ready = 1;
      cyc(); cyc(); cyc();
   endtask

   task automatic test_stall;
      logic [63:0] a, b;
      do_reset();
      cyc();
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      req1_valid = 1; req1_fn = 6'd2; req1_in1 = a; req1_in2 = b; alu_oval = 0;
      #1;
      vec++;
      if ({req1_ready, req0_ready} !== 2'b10) begin
         errs++; $display("FAIL stall_accept: got %b expected 10", {req1_ready, req0_ready});
      end
      for (int i = 0; i < 4; i++) begin
         cyc();
         req1_valid = 0; req1_in1 = '0;
         alu_oval = (i == 3);
         #1;
         vec++;
         if (alu_val !== 1'b1 || alu_fn !== 6'd2 || alu_in1 !== a || alu_in2 !== b || rsp1_valid !== 1'b0) begin
            errs++; $display("FAIL stall_hold[%0d]: got val=%b fn=%0d in1=%h in2=%h v=%b expected 1/2/%h/%h/0",
                             i, alu_val, alu_fn, alu_in1, alu_in2, rsp1_valid, a, b);
         end
      end
      cyc();
      rsp1_ready = 1;
      #1;
      vec++;
      if (rsp1_valid !== 1'b1 || rsp1_data !== (a | b) || alu_val !== 1'b0) begin
         errs++; $display("FAIL stall_result: got v=%b data=%h alu_val=%b expected 1/%h/0", rsp1_valid, rsp1_data, alu_val, a | b);
      end
      cyc();
   endtask

   task automatic test_fixed_prio;
      do_reset();
      cyc();
      req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
      req0_fn = 6'd1; req1_fn = 6'd1;
      for (int i = 0; i < 10; i++) begin
         automatic logic [1:0] exp_rdy;
         if (i > 0) cyc();
         if (i == 9) req0_valid = 0;
         exp_rdy = (i % 3 != 0) ? 2'b00 : (i == 9 ? 2'b10 : 2'b01);
         #1;
         vec++;
         if ({fp_req1_ready, fp_req0_ready} !== exp_rdy) begin
            errs++; $display("FAIL fixed_prio[%0d]: got %b expected %b", i, {fp_req1_ready, fp_req0_ready}, exp_rdy);
         end
      end
      req1_valid = 0;
      cyc(); cyc(); cyc();
   endtask

   task automatic test_reset_mid;
      do_reset();
      cyc();
      req0_valid = 1; req0_fn = 6'd1; req0_in1 = 64'hABCD; req0_in2 = 64'h1;
      cyc();
      req0_valid = 0;
      cyc();
      vec++;
      if (rsp0_valid !== 1'b1) begin
         errs++; $display("FAIL rmid_pre: got rsp0_valid=%b expected 1", rsp0_valid);
      end
      #2 ise_rst = 1;
      #1;
      vec++;
      if ({rsp0_valid, rsp1_valid, alu_val, req0_ready, req1_ready} !== 5'b0 || rsp0_data !== '0 || alu_in1 !== '0) begin
         errs++; $display("FAIL rmid_async: got ctl=%b data=%h in1=%h expected 0",
                          {rsp0_valid, rsp1_valid, alu_val, req0_ready, req1_ready}, rsp0_data, alu_in1);
      end
      cyc();
      ise_rst = 0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         vec++;
         if ({rsp0_valid, rsp1_valid, alu_val} !== 3'b0) begin
            errs++; $display("FAIL rmid_after[%0d]: got %b expected 000", i, {rsp0_valid, rsp1_valid, alu_val});
         end
      end
   endtask

   task automatic test_random;
      logic           lp_m;
      logic           w;
      logic [FNW-1:0] fn_e;
      logic [63:0]    a_e, b_e, r_e;
      int             ops;
      logic [FNW-1:0] fns [4];
      fns[0] = 6'd35; fns[1] = 6'd1; fns[2] = 6'd2; fns[3] = 6'd50;
      do_reset();
      lp_m = 1'b1;
      ops = 0;
      for (int it = 0; it < 120 && ops < 30; it++) begin
         cyc();
         req0_valid = $urandom_range(0, 1); req1_valid = $urandom_range(0, 1);
         req0_fn = fns[$urandom_range(0, 3)]; req1_fn = fns[$urandom_range(0, 3)];
         req0_in1 = {$urandom, $urandom}; req0_in2 = {$urandom, $urandom};
         req1_in1 = {$urandom, $urandom}; req1_in2 = {$urandom, $urandom};
         rsp0_ready = 0; rsp1_ready = 0;
         #1;
         vec++;
         if (!req0_valid && !req1_valid) begin
            if ({req1_ready, req0_ready} !== 2'b00) begin
               errs++; $display("FAIL rnd_idle: got %b expected 00", {req1_ready, req0_ready});
            end
            continue;
         end
         w = (req0_valid && req1_valid) ? ~lp_m : req1_valid;
         lp_m = w;
         if ({req1_ready, req0_ready} !== (w ? 2'b10 : 2'b01)) begin
            errs++; $display("FAIL rnd_grant: got %b expected port %0d", {req1_ready, req0_ready}, w);
         end
         fn_e = w ? req1_fn : req0_fn;
         a_e  = w ? req1_in1 : req0_in1;
         b_e  = w ? req1_in2 : req0_in2;
         r_e  = alu_ref(fn_e, a_e, b_e);
         ops++;
         begin
            automatic int k = $urandom_range(0, 2);
            for (int j = 0; j <= k; j++) begin
               cyc();
               alu_oval = (j == k);
               req0_valid = $urandom_range(0, 1); req1_valid = $urandom_range(0, 1);
               req0_in1 = {$urandom, $urandom};
               #1;
               vec++;
               if (alu_val !== 1'b1 || alu_fn !== fn_e || alu_in1 !== a_e || alu_in2 !== b_e || {req1_ready, req0_ready} !== 2'b00) begin
                  errs++; $display("FAIL rnd_issue: got val=%b fn=%0d in1=%h in2=%h rdy=%b expected 1/%0d/%h/%h/00",
                                   alu_val, alu_fn, alu_in1, alu_in2, {req1_ready, req0_ready}, fn_e, a_e, b_e);
               end
            end
         end
         begin
            automatic int d = $urandom_range(0, 2);
            for (int j = 0; j <= d; j++) begin
               cyc();
               alu_oval = $urandom_range(0, 1);
               rsp0_ready = w ? 1'($urandom_range(0, 1)) : (j == d);
               rsp1_ready = w ? (j == d) : 1'($urandom_range(0, 1));
               #1;
               vec++;
               if ({rsp1_valid, rsp0_valid} !== (w ? 2'b10 : 2'b01) || rsp0_data !== r_e || rsp1_data !== r_e ||
                   {req1_ready, req0_ready} !== 2'b00) begin
                  errs++; $display("FAIL rnd_resp: got v=%b data=%h rdy=%b expected port %0d data=%h",
                                   {rsp1_valid, rsp0_valid}, rsp0_data, {req1_ready, req0_ready}, w, r_e);
               end
            end
         end
         alu_oval = 1;
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_single_op();
      test_tie_rr();
      test_backpressure();
      test_stall();
      test_fixed_prio();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
